// File: rtl/sdram_uart_pkg.sv
// Shared definitions for the UART-to-SDRAM command path: decoder state
// encoding and default command byte values used by both RX and TX framers.
package sdram_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        WDONE = 2'd2
    } dec_state_e;

    localparam logic [7:0] CMD_WR_DEF = 8'h55;
    localparam logic [7:0] CMD_RD_DEF = 8'hAA;

endpackage

// File: rtl/uart_gap_timer.sv
// Idle-gap watchdog: counts enabled cycles since the last clear and raises
// a single-cycle expire when LIMIT enabled cycles pass without a clear.
module uart_gap_timer #(
    parameter int LIMIT = 150000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int TW = $clog2(LIMIT + 1);
    localparam logic [TW-1:0] LAST = TW'(LIMIT - 1);
    localparam logic [TW-1:0] SAT  = TW'(LIMIT);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Counting on past LAST to SAT and parking there keeps expire one-shot
    // even if the owner leaves en high after the pulse.
    always_comb begin
        cnt_d  = cnt_q;
        expire = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                expire = 1'b1;
            end
            if (cnt_q != SAT) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_decode.sv
// Parses the UART receive byte stream into SDRAM write-FIFO pushes plus
// write/read trigger pulses; malformed or stalled frames raise frame_err.
module uart_cmd_decode
    import sdram_uart_pkg::*;
#(
    parameter int         WR_LEN      = 4,
    parameter logic [7:0] CMD_WR      = CMD_WR_DEF,
    parameter logic [7:0] CMD_RD      = CMD_RD_DEF,
    parameter int         TIMEOUT_CYC = 150000
) (
    input  logic       sclk,
    input  logic       s_rst,
    input  logic [7:0] uart_data,
    input  logic       uart_flag,
    output logic       wfifo_wr_en,
    output logic [7:0] wfifo_data,
    output logic       wr_trig,
    output logic       rd_trig,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [7:0] LAST_IDX = 8'(WR_LEN - 1);

    dec_state_e state_q, state_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic       wfifo_wr_en_q, wfifo_wr_en_d;
    logic [7:0] wfifo_data_q, wfifo_data_d;
    logic       wr_trig_q, wr_trig_d;
    logic       rd_trig_q, rd_trig_d;
    logic       frame_err_q, frame_err_d;
    logic       busy_q, busy_d;

    logic gap_clr;
    logic gap_en;
    logic gap_expire;

    // Any accepted byte restarts the gap; outside a frame it is held at zero.
    assign gap_clr = (state_q != WDATA) || uart_flag;
    assign gap_en  = (state_q == WDATA);

    uart_gap_timer #(
        .LIMIT (TIMEOUT_CYC)
    ) u_gap_timer (
        .clk    (sclk),
        .rst    (s_rst),
        .clr    (gap_clr),
        .en     (gap_en),
        .expire (gap_expire)
    );

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        wfifo_wr_en_d = 1'b0;
        wfifo_data_d  = wfifo_data_q;
        wr_trig_d     = 1'b0;
        rd_trig_d     = 1'b0;
        frame_err_d   = 1'b0;

        case (state_q)
            WDATA: begin
                if (uart_flag) begin
                    wfifo_wr_en_d = 1'b1;
                    wfifo_data_d  = uart_data;
                    byte_cnt_d    = byte_cnt_q + 8'd1;
                    if (byte_cnt_q == LAST_IDX) begin
                        state_d    = WDONE;
                        byte_cnt_d = 8'd0;
                    end
                end else if (gap_expire) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                    byte_cnt_d  = 8'd0;
                end
            end
            IDLE, WDONE: begin
                // WDONE trails the last push by one cycle so the FIFO has
                // committed it; a byte landing here is still decoded.
                if (state_q == WDONE) begin
                    wr_trig_d = 1'b1;
                    state_d   = IDLE;
                end
                if (uart_flag) begin
                    if (uart_data == CMD_WR) begin
                        state_d    = WDATA;
                        byte_cnt_d = 8'd0;
                    end else if (uart_data == CMD_RD) begin
                        rd_trig_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                byte_cnt_d = 8'd0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state_q       <= IDLE;
            byte_cnt_q    <= 8'd0;
            wfifo_wr_en_q <= 1'b0;
            wfifo_data_q  <= 8'h00;
            wr_trig_q     <= 1'b0;
            rd_trig_q     <= 1'b0;
            frame_err_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            wfifo_wr_en_q <= wfifo_wr_en_d;
            wfifo_data_q  <= wfifo_data_d;
            wr_trig_q     <= wr_trig_d;
            rd_trig_q     <= rd_trig_d;
            frame_err_q   <= frame_err_d;
            busy_q        <= busy_d;
        end
    end

    assign wfifo_wr_en = wfifo_wr_en_q;
    assign wfifo_data  = wfifo_data_q;
    assign wr_trig     = wr_trig_q;
    assign rd_trig     = rd_trig_q;
    assign frame_err   = frame_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_cmd_decode.sv
// Bench for uart_cmd_decode: byte events are turned into per-cycle expected
// outputs by a frame-level model, then every cycle of the DUT is compared.
module tb_uart_cmd_decode;

    localparam int         TO   = 100;
    localparam int         WRL  = 4;
    localparam logic [7:0] CW   = 8'h55;
    localparam logic [7:0] CR   = 8'hAA;
    localparam int         MAXC = 8192;

    logic       sclk = 1'b0;
    logic       s_rst;
    logic [7:0] uart_data;
    logic       uart_flag;
    logic       wfifo_wr_en;
    logic [7:0] wfifo_data;
    logic       wr_trig;
    logic       rd_trig;
    logic       frame_err;
    logic       busy;

    always #5 sclk = ~sclk;

    uart_cmd_decode #(
        .WR_LEN      (WRL),
        .CMD_WR      (CW),
        .CMD_RD      (CR),
        .TIMEOUT_CYC (TO)
    ) dut (
        .sclk        (sclk),
        .s_rst       (s_rst),
        .uart_data   (uart_data),
        .uart_flag   (uart_flag),
        .wfifo_wr_en (wfifo_wr_en),
        .wfifo_data  (wfifo_data),
        .wr_trig     (wr_trig),
        .rd_trig     (rd_trig),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    int checks   = 0;
    int failures = 0;

    int         ev_gap[$];
    logic [7:0] ev_byte[$];

    logic       st_f [MAXC];
    logic [7:0] st_d [MAXC];
    logic       e_we [MAXC];
    logic [7:0] e_wd [MAXC];
    logic       e_wt [MAXC];
    logic       e_rt [MAXC];
    logic       e_fe [MAXC];
    logic       e_bs [MAXC];

    task automatic check(input string tag, input int cyc, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic add(input int gap, input logic [7:0] b);
        ev_gap.push_back(gap);
        ev_byte.push_back(b);
    endtask

    // Model: a frame opened by CMD_WR accepts WRL bytes; it is aborted at
    // L+TO when no byte arrives within TO cycles of the last one at L.
    task automatic run_seq(input string name);
        int         t;
        int         len;
        int         s_t;
        int         l_t;
        int         cnt;
        bit         inframe;
        logic [7:0] b;
        for (int c = 0; c < MAXC; c++) begin
            st_f[c] = 1'b0; st_d[c] = 8'h00; e_we[c] = 1'b0; e_wd[c] = 8'h00;
            e_wt[c] = 1'b0; e_rt[c] = 1'b0; e_fe[c] = 1'b0; e_bs[c] = 1'b0;
        end
        t = 0; s_t = 0; l_t = 0; cnt = 0; inframe = 1'b0;
        for (int i = 0; i < ev_gap.size(); i++) begin
            t += ev_gap[i];
            b = ev_byte[i];
            st_f[t] = 1'b1;
            st_d[t] = b;
            if (inframe && (t - l_t > TO)) begin
                e_fe[l_t + TO] = 1'b1;
                for (int k = s_t; k < l_t + TO; k++) e_bs[k] = 1'b1;
                inframe = 1'b0;
            end
            if (!inframe) begin
                if (b == CW) begin
                    inframe = 1'b1; s_t = t; l_t = t; cnt = 0;
                end else if (b == CR) begin
                    e_rt[t] = 1'b1;
                end else begin
                    e_fe[t] = 1'b1;
                end
            end else begin
                e_we[t] = 1'b1;
                e_wd[t] = b;
                cnt++;
                l_t = t;
                if (cnt == WRL) begin
                    e_wt[t + 1] = 1'b1;
                    for (int k = s_t; k <= t; k++) e_bs[k] = 1'b1;
                    inframe = 1'b0;
                end
            end
        end
        if (inframe) begin
            e_fe[l_t + TO] = 1'b1;
            for (int k = s_t; k < l_t + TO; k++) e_bs[k] = 1'b1;
        end
        len = t + TO + 5;
        $display("seq %s: events=%0d cycles=%0d", name, ev_gap.size(), len);
        for (int c = 0; c < len; c++) begin
            uart_flag = st_f[c];
            uart_data = st_f[c] ? st_d[c] : 8'($urandom);
            @(negedge sclk);
            check({name, ".wr_en"},     c, {7'd0, wfifo_wr_en}, {7'd0, e_we[c]});
            if (e_we[c]) check({name, ".data"}, c, wfifo_data, e_wd[c]);
            check({name, ".wr_trig"},   c, {7'd0, wr_trig},   {7'd0, e_wt[c]});
            check({name, ".rd_trig"},   c, {7'd0, rd_trig},   {7'd0, e_rt[c]});
            check({name, ".frame_err"}, c, {7'd0, frame_err}, {7'd0, e_fe[c]});
            check({name, ".busy"},      c, {7'd0, busy},      {7'd0, e_bs[c]});
        end
        uart_flag = 1'b0;
        ev_gap.delete();
        ev_byte.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".wr_en"},     0, {7'd0, wfifo_wr_en}, 8'h00);
        check({tag, ".data"},      0, wfifo_data,          8'h00);
        check({tag, ".wr_trig"},   0, {7'd0, wr_trig},     8'h00);
        check({tag, ".rd_trig"},   0, {7'd0, rd_trig},     8'h00);
        check({tag, ".frame_err"}, 0, {7'd0, frame_err},   8'h00);
        check({tag, ".busy"},      0, {7'd0, busy},        8'h00);
    endtask

    task automatic send_now(input logic [7:0] b);
        uart_flag = 1'b1;
        uart_data = b;
        @(negedge sclk);
        uart_flag = 1'b0;
    endtask

    initial begin
        int         g;
        int         r;
        logic [7:0] b;

        s_rst     = 1'b1;
        uart_flag = 1'b0;
        uart_data = 8'h00;
        repeat (2) @(negedge sclk);
        check_all_zero("reset");
        s_rst = 1'b0;
        @(negedge sclk);

        add(2, CW); add(10, 8'h11); add(10, 8'h22); add(10, 8'h33); add(10, 8'h44);
        run_seq("write");

        add(3, CR);
        run_seq("read");

        add(3, 8'h3C); add(5, CR);
        run_seq("unknown");

        add(2, CW); add(4, 8'h11); add(TO + 20, CR);
        run_seq("timeout");

        add(2, CW); add(4, 8'h11); add(TO, 8'h22); add(TO - 1, 8'h33); add(3, 8'h44);
        run_seq("limit");

        add(2, CW); add(3, CR); add(3, CW); add(3, CR); add(3, 8'h00);
        run_seq("cmd_payload");

        send_now(CW);
        repeat (3) @(negedge sclk);
        send_now(8'h11);
        repeat (3) @(negedge sclk);
        send_now(8'h22);
        check("rst_pre.wr_en", 0, {7'd0, wfifo_wr_en}, 8'h01);
        check("rst_pre.data",  0, wfifo_data,          8'h22);
        check("rst_pre.busy",  0, {7'd0, busy},        8'h01);
        #1 s_rst = 1'b1;
        #1 check_all_zero("rst_async");
        repeat (3) @(negedge sclk);
        check_all_zero("rst_held");
        s_rst = 1'b0;
        add(2, CW); add(5, 8'h01); add(5, 8'h02); add(5, 8'h03); add(5, 8'h04);
        run_seq("after_reset");

        for (int run = 0; run < 3; run++) begin
            for (int i = 0; i < 30; i++) begin
                if ($urandom_range(0, 9) == 0) g = TO - 1 + int'($urandom_range(0, 2));
                else g = int'($urandom_range(2, 12));
                r = int'($urandom_range(0, 99));
                if (r < 30) b = CW;
                else if (r < 45) b = CR;
                else b = 8'($urandom);
                add(g, b);
            end
            run_seq($sformatf("random%0d", run));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
